// File: rtl/cs_sched_pkg.sv
// Shared definitions for the 74138 chip-select scheduler.
//   NUM_REQ / SEL_W : requester count and decoder select width
//   state_e         : scheduler FSM states
//   DEC_ON/DEC_OFF  : decoder enable triplet {g1, g2a_n, g2b_n}
package cs_sched_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StActive,
        StRecover
    } state_e;

    // Bit order is {g1, g2a_n, g2b_n}
    localparam logic [2:0] DEC_ON  = 3'b100;
    localparam logic [2:0] DEC_OFF = 3'b011;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req_i   : request vector
//   ptr_i   : highest-priority index for this pick
//   valid_o : at least one request present
//   idx_o   : first set request searching ptr_i upward with wrap
module rr_pick
    import cs_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [SEL_W-1:0]   idx_o
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        cand    = '0;
        valid_o = 1'b0;
        idx_o   = ptr_i;
        // Scan from the farthest offset down so the nearest hit is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr_i + SEL_W'(i);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/cs_scheduler_74138.sv
// Round-robin chip-select scheduler sharing one 74138 decoder among 8 requesters.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   en_i                  : allows new grants from IDLE
//   req_i                 : per-requester request, held for the whole access
//   select_{a,b,c}_o      : decoder select lines (a = LSB)
//   g1_en_o, g2a/g2b_en_n_o : decoder enables, always switched together
//   gnt_o                 : one-hot grant, valid only while decoder enabled
//   busy_o                : scheduler not idle
//   timeout_o             : one-cycle pulse on forced release at MAX_HOLD
module cs_scheduler_74138
    import cs_sched_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned MAX_HOLD       = 16,
    parameter int unsigned RECOVER_CYCLES = 1,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic               select_a_o,
    output logic               select_b_o,
    output logic               select_c_o,
    output logic               g1_en_o,
    output logic               g2a_en_n_o,
    output logic               g2b_en_n_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               busy_o,
    output logic               timeout_o
);

    // Terminal counts; only meaningful when the matching phase is enabled.
    localparam logic [CNT_W-1:0] SetupLast   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] RecoverLast = CNT_W'(RECOVER_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [2:0]         dec_en_q, dec_en_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;

    rr_pick u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= '0;
            sel_q     <= '0;
            dec_en_q  <= DEC_OFF;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            dec_en_q  <= dec_en_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en_i && pick_valid) begin
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = (SETUP_CYCLES == 0) ? StActive : StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StActive: begin
                // cnt_q counts completed ACTIVE cycles before this edge.
                if (!req_i[sel_q] || cnt_q == HoldLast) begin
                    timeout_d = req_i[sel_q];
                    ptr_d     = sel_q + 1'b1;
                    cnt_d     = '0;
                    state_d   = (RECOVER_CYCLES == 0) ? StIdle : StRecover;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRecover: begin
                if (cnt_q == RecoverLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state; select lines stay frozen across SETUP and ACTIVE.
    always_comb begin
        dec_en_d = DEC_OFF;
        gnt_d    = '0;
        busy_d   = (state_d != StIdle);
        if (state_d == StActive) begin
            dec_en_d     = DEC_ON;
            gnt_d[sel_d] = 1'b1;
        end
    end

    assign select_a_o = sel_q[0];
    assign select_b_o = sel_q[1];
    assign select_c_o = sel_q[2];
    assign g1_en_o    = dec_en_q[2];
    assign g2a_en_n_o = dec_en_q[1];
    assign g2b_en_n_o = dec_en_q[0];
    assign gnt_o      = gnt_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule

// File: doc/cs_scheduler_74138.md
Name: cs_scheduler_74138

Overview:
Round-robin chip-select scheduler that shares one 74138 3-to-8 decoder among 8 requesters. It drives the decoder select lines (A/B/C) and enables (G1, G2A_n, G2B_n). Select lines settle before the enables assert, each grant's hold time is bounded, and a recovery gap separates consecutive grants. It sits between the bus-master request logic and the decoder that generates active-low peripheral chip selects.

Parameters:
SETUP_CYCLES, 1, cycles select lines are held stable with enables deasserted before the grant (0 = skip SETUP)
MAX_HOLD, 16, maximum ACTIVE cycles per grant before forced release (>=1)
RECOVER_CYCLES, 1, cycles enables stay deasserted after a release before the next grant (0 = skip RECOVER)
CNT_W, 8, width of the shared phase counter; must hold max(SETUP_CYCLES, MAX_HOLD, RECOVER_CYCLES)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
en_i  in  1  scheduler enable; low blocks new grants and does not abort an ACTIVE grant
req_i  in  8  request per requester; held high for the whole access
select_a_o  out  1  decoder select A (LSB of granted index)
select_b_o  out  1  decoder select B
select_c_o  out  1  decoder select C (MSB)
g1_en_o  out  1  decoder G1 enable, active-high
g2a_en_n_o  out  1  decoder G2A enable, active-low
g2b_en_n_o  out  1  decoder G2B enable, active-low
gnt_o  out  8  one-hot grant, asserted only while decoder enables are asserted
busy_o  out  1  high in any state other than IDLE
timeout_o  out  1  one-cycle pulse on forced release at MAX_HOLD

Behaviour:
- All outputs are registered. Reset values: select_{a,b,c}_o=0, g1_en_o=0, g2a_en_n_o=1, g2b_en_n_o=1, gnt_o=0, busy_o=0, timeout_o=0. Round-robin pointer ptr=0, state IDLE, counter 0.
- Decoder enabled means g1=1, g2a_n=0, g2b_n=0. Disabled means g1=0, g2a_n=1, g2b_n=1. The three enable outputs always change together.
- FSM states: IDLE, SETUP, ACTIVE, RECOVER.
- IDLE: if en_i=1 and req_i!=0, pick the first set bit searching from ptr upward with wrap (ptr..7, then 0..ptr-1). At the same edge, load the index into select_{c,b,a}_o and go to SETUP (or ACTIVE if SETUP_CYCLES=0). Select lines hold their last value while in IDLE.
- SETUP: enables stay disabled and select lines are frozen. After SETUP_CYCLES cycles, go to ACTIVE.
- ACTIVE entry edge: enables assert and gnt_o[idx]=1.
- Latency: with SETUP_CYCLES=1, a request sampled at edge N gives select valid after N and enables/gnt valid after N+1.
- ACTIVE: the counter counts ACTIVE cycles.
  - req_i[idx] sampled low: disable enables, clear gnt_o, go to RECOVER at that edge.
  - Counter reaches MAX_HOLD with req still high: same exit, plus timeout_o=1 for one cycle.
  - Either exit sets ptr=(idx+1) mod 8. Changes to other req bits are ignored during ACTIVE.
- RECOVER: enables stay disabled for RECOVER_CYCLES cycles, then go to IDLE. Arbitration for the next grant happens in IDLE, so the minimum gap between grants is RECOVER_CYCLES+1 idle-enable cycles plus SETUP_CYCLES.
- en_i low: only affects IDLE (no new grant). SETUP and ACTIVE complete normally.
- A requester that dropped its request during SETUP still gets the ACTIVE entry. It is then released after 1 ACTIVE cycle.
- Reset asserted in any state: at the next edge, return to reset values. Enables are disabled immediately and no partial grant remains.
- Invariants:
  - gnt_o is either zero or one-hot.
  - gnt_o!=0 if and only if the decoder is enabled.
  - Select lines never change while the decoder is enabled.

Decomposition:
- Package cs_sched_pkg:
  - NUM_REQ=8, SEL_W=3
  - state enum typedef (IDLE, SETUP, ACTIVE, RECOVER)
  - constants for the enabled/disabled enable triplets
- Sub-module rr_pick: combinational round-robin selector. Inputs: req[7:0], ptr[2:0]. Outputs: valid, idx[2:0].

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, req_i=0 -> g1=0, g2a_n=1, g2b_n=1, gnt_o=00000000, busy_o=0, selects=000.
- Single request: en_i=1, req_i=00100000 held 5 cycles then dropped -> selects=101 one cycle before enables assert. gnt_o=00100000 for 5 cycles, then enables drop. busy_o falls after RECOVER.
- Round robin: req_i=11111111 held (each requester drops its req after 2 ACTIVE cycles) -> grant order 0,1,2,…,7,0. The select value increments each grant, and there are no back-to-back enable cycles without a RECOVER gap.
- Timeout: MAX_HOLD=4, req_i[3] held high forever -> enables asserted exactly 4 cycles, timeout_o pulses once, and the next grant goes to index 3 again only after RECOVER+SETUP.
- en_i gating: en_i=0 with req_i=00000010 -> no grant. Raise en_i -> grant idx 1. Drop en_i mid-ACTIVE -> grant continues until req_i[1] falls.
- Reset mid-ACTIVE: assert rst_i while gnt_o=00010000 -> at the next edge enables are disabled, gnt_o=0, selects=000, ptr=0. After reset, req_i=10010001 grants idx 0 first.
